// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM. Steps each instruction through fetch, decode,
// execute, memory and writeback, drives the shared datapath enables every cycle,
// handshakes with a variable-latency unified memory and traps on bad encodings
// or on a memory access that is never acknowledged.

package multicycle_control_unit_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;
endpackage

module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int SUPPORT_JUMP = 1,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_instr,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output alu_op_t     ALUOp,
    output logic        reg_write,
    output logic [1:0]  mem_to_reg,
    output logic        illegal_instr,
    output logic        mem_timeout,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam int            TO_LAST   = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam int            CW        = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;
    localparam logic [CW-1:0] TO_LAST_W = CW'(TO_LAST);
    localparam logic          JUMPS     = (SUPPORT_JUMP != 0);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          illegal_flag;
    logic          timeout_flag;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r, is_i, is_load, is_store, is_branch;
    logic       is_jal, is_jalr, is_lui, is_auipc;
    logic       known_op, bad_r, bad_shift, bad_load, bad_store, bad_branch, bad_encoding;
    logic       in_access, wait_expired;
    alu_op_t    funct_op, branch_op;
    logic       branch_cond, branch_taken;
    logic       unused_instr;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    assign is_r      = (opcode == 7'b0110011);
    assign is_i      = (opcode == 7'b0010011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = JUMPS && (opcode == 7'b1101111);
    assign is_jalr   = JUMPS && (opcode == 7'b1100111);
    assign is_lui    = JUMPS && (opcode == 7'b0110111);
    assign is_auipc  = JUMPS && (opcode == 7'b0010111);

    assign known_op   = is_r | is_i | is_load | is_store | is_branch |
                        is_jal | is_jalr | is_lui | is_auipc;
    assign bad_r      = is_r && !((funct7 == 7'h00) ||
                                  ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
    assign bad_shift  = is_i && (((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                                 ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20)));
    assign bad_load   = is_load && ((funct3 == 3'd3) || (funct3[2:1] == 2'b11));
    assign bad_store  = is_store && (funct3 > 3'd2);
    assign bad_branch = is_branch && (funct3[2:1] == 2'b01);
    assign bad_encoding = !known_op || bad_r || bad_shift || bad_load || bad_store || bad_branch;

    // Map funct3 plus the alternate bit onto an ALU operation; only R-type may select SUB
    always_comb begin
        funct_op = ALU_ADD;
        case (funct3)
            3'd0:    funct_op = (is_r && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'd1:    funct_op = ALU_SLL;
            3'd2:    funct_op = ALU_SLT;
            3'd3:    funct_op = ALU_SLTU;
            3'd4:    funct_op = ALU_XOR;
            3'd5:    funct_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'd6:    funct_op = ALU_OR;
            default: funct_op = ALU_AND;
        endcase
    end

    // Branches compare by subtraction (EQ/NE) or set-less-than; funct3[0] inverts the condition
    always_comb begin
        branch_op   = ALU_SUB;
        branch_cond = alu_zero;
        if (funct3[2]) begin
            branch_op   = funct3[1] ? ALU_SLTU : ALU_SLT;
            branch_cond = alu_lt;
        end
    end

    assign branch_taken = branch_cond ^ funct3[0];
    assign in_access    = (state == S_FETCH) || (state == S_MEM);
    assign wait_expired = (MEM_TIMEOUT > 0) && in_access && !mem_ack && (wait_cnt == TO_LAST_W);

    // State sequencing, memory wait counter and the sticky trap cause flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            wait_cnt     <= '0;
            illegal_flag <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                S_FETCH, S_MEM: begin
                    if (mem_ack) begin
                        wait_cnt <= '0;
                        if (state == S_FETCH)
                            state <= S_DECODE;
                        else
                            state <= is_store ? S_FETCH : S_WB;
                    end else if (wait_expired) begin
                        wait_cnt     <= '0;
                        state        <= S_TRAP;
                        timeout_flag <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (bad_encoding) begin
                        state        <= S_TRAP;
                        illegal_flag <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load || is_store)
                        state <= S_MEM;
                    else if (is_branch)
                        state <= S_FETCH;
                    else
                        state <= S_WB;
                end
                S_WB:    state <= S_FETCH;
                S_TRAP:  state <= S_TRAP;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Datapath controls decoded from the current state and IR so enables act in the same cycle
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_instr = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        ALUOp        = ALU_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 2'd0;
        if (!rst) begin
            if ((state == S_EXEC) || (state == S_MEM)) begin
                if (is_r) begin
                    ALUOp = funct_op;
                end else if (is_i) begin
                    ALUOp     = funct_op;
                    alu_src_b = 2'd1;
                end else if (is_branch) begin
                    ALUOp = branch_op;
                end else if (is_lui) begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd1;
                end else if (is_auipc) begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                end else if (is_load || is_store || is_jalr) begin
                    alu_src_b = 2'd1;
                end
            end
            case (state)
                S_FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_instr = 1'b1;
                    if (mem_ack) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                S_EXEC: begin
                    if ((is_branch && branch_taken) || is_jal) begin
                        pc_we  = 1'b1;
                        pc_src = 2'd1;
                    end else if (is_jalr) begin
                        pc_we  = 1'b1;
                        pc_src = 2'd2;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (is_load)
                        mem_to_reg = 2'd1;
                    else if (is_jal || is_jalr)
                        mem_to_reg = 2'd2;
                end
                default: ;
            endcase
        end
    end

    assign illegal_instr = illegal_flag && !rst;
    assign mem_timeout   = timeout_flag && !rst;
    assign state_dbg     = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. A transaction-level model
// predicts, for each instruction and chosen memory latencies, the sequence of
// states and the datapath controls each of those cycles must show.

module tb_multicycle_control_unit;
    import multicycle_control_unit_pkg::*;

    typedef enum logic [3:0] {
        K_ILL, K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC
    } kind_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        alu_zero, alu_lt, mem_ack;
    logic        mem_req, mem_we, mem_is_instr, ir_we, pc_we, reg_write;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, mem_to_reg;
    alu_op_t     ALUOp;
    logic        illegal_instr, mem_timeout;
    logic [2:0]  state_dbg;

    logic        j_mem_req, j_mem_we, j_mem_is_instr, j_ir_we, j_pc_we, j_reg_write;
    logic [1:0]  j_pc_src, j_alu_src_a, j_alu_src_b, j_mem_to_reg;
    alu_op_t     j_ALUOp;
    logic        j_illegal_instr, j_mem_timeout;
    logic [2:0]  j_state_dbg;

    int total = 0;
    int bad   = 0;

    logic [22:0] obs_q[$];
    logic [22:0] exp_q[$];
    logic [22:0] msk_q[$];

    multicycle_control_unit #(.SUPPORT_JUMP(1), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_is_instr(mem_is_instr),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ALUOp(ALUOp), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal_instr(illegal_instr), .mem_timeout(mem_timeout), .state_dbg(state_dbg)
    );

    multicycle_control_unit #(.SUPPORT_JUMP(0), .MEM_TIMEOUT(0)) dut_nojump (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .mem_ack(mem_ack), .mem_req(j_mem_req), .mem_we(j_mem_we), .mem_is_instr(j_mem_is_instr),
        .ir_we(j_ir_we), .pc_we(j_pc_we), .pc_src(j_pc_src), .alu_src_a(j_alu_src_a),
        .alu_src_b(j_alu_src_b), .ALUOp(j_ALUOp), .reg_write(j_reg_write), .mem_to_reg(j_mem_to_reg),
        .illegal_instr(j_illegal_instr), .mem_timeout(j_mem_timeout), .state_dbg(j_state_dbg)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [22:0] obs_vec();
        return {state_dbg, mem_req, mem_is_instr, mem_we, ir_we, pc_we, pc_src,
                alu_src_a, alu_src_b, 4'(ALUOp), reg_write, mem_to_reg, illegal_instr, mem_timeout};
    endfunction

    // Instruction class and legality from the RV32I encoding rules
    function automatic kind_t classify(input logic [31:0] ins, input bit jumps);
        logic [2:0] f3;
        logic [6:0] f7;
        kind_t      k;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33: k = (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) ? K_R : K_ILL;
            7'h13: begin
                if (f3 == 1)      k = (f7 == 7'h00) ? K_I : K_ILL;
                else if (f3 == 5) k = (f7 == 7'h00 || f7 == 7'h20) ? K_I : K_ILL;
                else              k = K_I;
            end
            7'h03: k = (f3 == 3 || f3 >= 6) ? K_ILL : K_LD;
            7'h23: k = (f3 <= 2) ? K_ST : K_ILL;
            7'h63: k = (f3 == 2 || f3 == 3) ? K_ILL : K_BR;
            7'h6F: k = jumps ? K_JAL : K_ILL;
            7'h67: k = jumps ? K_JALR : K_ILL;
            7'h37: k = jumps ? K_LUI : K_ILL;
            7'h17: k = jumps ? K_AUIPC : K_ILL;
            default: k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] model_alu(input logic [31:0] ins, input bit is_reg);
        alu_op_t tbl [8];
        alu_op_t r;
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        r = tbl[ins[14:12]];
        if (ins[14:12] == 3'd5 && ins[30]) r = ALU_SRA;
        if (is_reg && ins[14:12] == 3'd0 && ins[30]) r = ALU_SUB;
        return 4'(r);
    endfunction

    function automatic logic [3:0] model_branch_op(input logic [31:0] ins);
        case (ins[14:12])
            3'd0, 3'd1: return 4'(ALU_SUB);
            3'd4, 3'd5: return 4'(ALU_SLT);
            default:    return 4'(ALU_SLTU);
        endcase
    endfunction

    function automatic bit model_taken(input logic [31:0] ins, input bit z, input bit l);
        case (ins[14:12])
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return l;
            3'd5:    return !l;
            3'd6:    return l;
            default: return !l;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [10];
        logic [31:0] r;
        int          sel;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
        r   = $urandom;
        sel = $urandom_range(0, 9);
        r[6:0] = (sel == 9) ? 7'($urandom) : ops[sel];
        if (sel <= 1) begin
            case ($urandom_range(0, 3))
                0, 1:    r[31:25] = 7'h00;
                2:       r[31:25] = 7'h20;
                default: ;
            endcase
        end
        return r;
    endfunction

    task automatic do_reset();
        rst     = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one instruction through its whole predicted trace, collecting observed and expected controls
    task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait,
                             input bit z, input bit l);
        kind_t       k;
        int          ph[$];
        int          fcnt, mcnt, p;
        bit          ack, tk, srcm, opm, pcw, rq;
        logic [1:0]  psrc, sa, sb, m2r;
        logic [3:0]  op;
        k  = classify(ins, 1'b1);
        tk = model_taken(ins, z, l);
        obs_q.delete(); exp_q.delete(); msk_q.delete();
        for (int i = 0; i <= fwait; i++) ph.push_back(0);
        ph.push_back(1);
        case (k)
            K_ILL: begin ph.push_back(5); ph.push_back(5); end
            K_BR:  ph.push_back(2);
            K_LD, K_ST: begin
                ph.push_back(2);
                for (int i = 0; i <= mwait; i++) ph.push_back(3);
                if (k == K_LD) ph.push_back(4);
            end
            default: begin ph.push_back(2); ph.push_back(4); end
        endcase
        fcnt = 0;
        mcnt = 0;
        foreach (ph[i]) begin
            p   = ph[i];
            ack = 1'b0;
            if (p == 0) begin ack = (fcnt == fwait); fcnt++; end
            if (p == 3) begin ack = (mcnt == mwait); mcnt++; end
            mem_ack  = ack;
            instr    = (p == 0) ? $urandom : ins;
            alu_zero = z;
            alu_lt   = l;
            #1;
            rq = (p == 0 || p == 3);
            pcw = 1'b0; psrc = 2'd0;
            if (p == 0 && ack) pcw = 1'b1;
            if (p == 2) begin
                if (k == K_BR)   begin pcw = tk;   psrc = 2'd1; end
                if (k == K_JAL)  begin pcw = 1'b1; psrc = 2'd1; end
                if (k == K_JALR) begin pcw = 1'b1; psrc = 2'd2; end
            end
            srcm = 1'b0; opm = 1'b0; sa = 2'd0; sb = 2'd0; op = 4'(ALU_ADD);
            if (p == 2 || p == 3) begin
                case (k)
                    K_R:        begin srcm = 1; opm = 1; op = model_alu(ins, 1'b1); end
                    K_I:        begin srcm = 1; opm = 1; sb = 2'd1; op = model_alu(ins, 1'b0); end
                    K_BR:       begin opm = 1; op = model_branch_op(ins); end
                    K_LD, K_ST,
                    K_JALR:     begin srcm = 1; opm = 1; sb = 2'd1; end
                    K_LUI:      begin srcm = 1; opm = 1; sa = 2'd2; sb = 2'd1; end
                    K_AUIPC:    begin srcm = 1; opm = 1; sa = 2'd1; sb = 2'd1; end
                    default: ;
                endcase
            end
            m2r = (k == K_LD) ? 2'd1 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0;
            exp_q.push_back({3'(p), rq, (p == 0), (p == 3 && k == K_ST), (p == 0 && ack), pcw, psrc,
                             sa, sb, op, (p == 4), m2r, (p == 5 && k == K_ILL), 1'b0});
            msk_q.push_back({3'h7, 1'b1, rq, 1'b1, 1'b1, 1'b1, {2{pcw}}, {2{srcm}}, {2{srcm}},
                             {4{opm}}, 1'b1, {2{p == 4}}, 1'b1, 1'b1});
            obs_q.push_back(obs_vec());
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [22:0] o;
        rst = 1'b1; mem_ack = 1'($urandom); instr = $urandom;
        alu_zero = 1'($urandom); alu_lt = 1'($urandom);
        #1;
        o = obs_vec();
        total++;
        if ((o & 23'h0BF0FF) !== 23'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want 000000 under mask 0bf0ff", o);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        o = obs_vec();
        total++;
        if ((o & 23'h7BF0FF) !== {3'd0, 12'd0, 4'(ALU_ADD), 4'd0}) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h want 000000 under mask 7bf0ff", o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        do_reset();
        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
        foreach (obs_q[i]) begin
            total++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                bad++;
                $display("[TB] FAIL add cyc%0d: got %h want %h mask %h", i, obs_q[i], exp_q[i], msk_q[i]);
            end
        end
    endtask

    task automatic test_load_wait();
        run_instr(32'h0000A183, 0, 2, 1'b0, 1'b0);
        total++;
        if (obs_q.size() != 7) begin
            bad++;
            $display("[TB] FAIL load_len: got %0d want 7", obs_q.size());
        end
        foreach (obs_q[i]) begin
            total++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                bad++;
                $display("[TB] FAIL load cyc%0d: got %h want %h mask %h", i, obs_q[i], exp_q[i], msk_q[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] prog [3];
        bit          zs   [3];
        prog = '{32'h00209463, 32'h00209463, 32'h002081B3};
        zs   = '{1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 3; n++) begin
            run_instr(prog[n], 0, 0, zs[n], 1'b0);
            foreach (obs_q[i]) begin
                total++;
                if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    bad++;
                    $display("[TB] FAIL branch%0d cyc%0d: got %h want %h mask %h",
                             n, i, obs_q[i], exp_q[i], msk_q[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        run_instr(32'h4000C0B3, 1, 0, 1'b0, 1'b0);
        foreach (obs_q[i]) begin
            total++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                bad++;
                $display("[TB] FAIL illegal cyc%0d: got %h want %h mask %h", i, obs_q[i], exp_q[i], msk_q[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1; instr = $urandom;
            #1;
            total++;
            if ({state_dbg, illegal_instr, mem_req, pc_we} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("[TB] FAIL trap_hold: got st=%0d ill=%b req=%b pcwe=%b want st=5 ill=1 req=0 pcwe=0",
                         state_dbg, illegal_instr, mem_req, pc_we);
            end
            @(negedge clk);
        end
        do_reset();
        #1;
        total++;
        if ({state_dbg, illegal_instr} !== {3'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL trap_clear: got st=%0d ill=%b want st=0 ill=0", state_dbg, illegal_instr);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b0;
            #1;
            total++;
            if ({state_dbg, mem_req} !== {3'd0, 1'b1}) begin
                bad++;
                $display("[TB] FAIL timeout_wait%0d: got st=%0d req=%b want st=0 req=1", i, state_dbg, mem_req);
            end
            @(negedge clk);
        end
        #1;
        total++;
        if ({state_dbg, mem_timeout, mem_req, illegal_instr} !== {3'd5, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL timeout_trap: got st=%0d tmo=%b req=%b ill=%b want st=5 tmo=1 req=0 ill=0",
                     state_dbg, mem_timeout, mem_req, illegal_instr);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            @(negedge clk);
        end
        #1;
        total++;
        if ({state_dbg, mem_timeout} !== {3'd1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL timeout_ack_wins: got st=%0d tmo=%b want st=1 tmo=0", state_dbg, mem_timeout);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        instr = 32'h0000A183; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        total++;
        if ({state_dbg, mem_req} !== {3'd3, 1'b1}) begin
            bad++;
            $display("[TB] FAIL mid_mem_setup: got st=%0d req=%b want st=3 req=1", state_dbg, mem_req);
        end
        rst = 1'b1;
        #1;
        total++;
        if (mem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_mem_req_drop: got req=%b want 0", mem_req);
        end
        @(negedge clk);
        #1;
        total++;
        if ({state_dbg, mem_req} !== {3'd0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL mid_mem_abort: got st=%0d req=%b want st=0 req=0", state_dbg, mem_req);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            #1;
            @(negedge clk);
        end
        #1;
        total++;
        if ({state_dbg, mem_timeout} !== {3'd1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL mid_mem_counter: got st=%0d tmo=%b want st=1 tmo=0", state_dbg, mem_timeout);
        end
    endtask

    task automatic test_nojump();
        logic [6:0]  ops [4];
        logic [31:0] ins;
        ops = '{7'h6F, 7'h67, 7'h37, 7'h17};
        for (int n = 0; n < 4; n++) begin
            do_reset();
            ins = $urandom;
            ins[6:0] = ops[n];
            ins[14:12] = 3'd0;
            mem_ack = 1'b1; instr = $urandom;
            #1;
            @(negedge clk);
            mem_ack = 1'b0; instr = ins;
            #1;
            @(negedge clk);
            #1;
            total++;
            if ({j_state_dbg, j_illegal_instr, state_dbg} !== {3'd5, 1'b1, 3'd2}) begin
                bad++;
                $display("[TB] FAIL nojump_op%h: got st=%0d ill=%b main_st=%0d want st=5 ill=1 main_st=2",
                         ops[n], j_state_dbg, j_illegal_instr, state_dbg);
            end
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins;
        for (int n = 0; n < 80; n++) begin
            ins = gen_instr();
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            foreach (obs_q[i]) begin
                total++;
                if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                    bad++;
                    $display("[TB] FAIL rand%0d ins=%h cyc%0d: got %h want %h mask %h",
                             n, ins, i, obs_q[i], exp_q[i], msk_q[i]);
                end
            end
            if (classify(ins, 1'b1) == K_ILL) do_reset();
        end
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1; mem_ack = 1'b0; instr = 32'h0; alu_zero = 1'b0; alu_lt = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_load_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        test_nojump();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
